// File: rtl/cl_tptn_gen_pkg.sv
// Shared types for the Camera Link test-pattern generator: FSM states,
// pattern mode codes, the control-bit payload and counter sizing helpers.
package cl_tptn_gen_pkg;

    localparam int unsigned FW = 16;  // frame counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FSETUP = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TPTN_HRAMP = 2'd0,
        TPTN_CHECK = 2'd1,
        TPTN_FIXED = 2'd2,
        TPTN_VRAMP = 2'd3
    } mode_e;

    // Control bits sitting above the pixel bus in dout.
    typedef struct packed {
        logic dval;
        logic fval;
        logic lval;
    } cl_ctl_t;

    // Bits needed to hold a count of 0..n (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cl_tptn_gen_pix.sv
// Per-tap pattern value: purely combinational, one instance per tap.
// All arithmetic wraps modulo 2**PW.
module cl_tptn_gen_pix
    import cl_tptn_gen_pkg::*;
#(
    parameter int unsigned PW  = 8,
    parameter int unsigned CHK = 2
) (
    input  mode_e         mode_i,
    input  logic [PW-1:0] p_i,
    input  logic [PW-1:0] y_i,
    input  logic [PW-1:0] f_i,
    input  logic [PW-1:0] fix_i,
    output logic [PW-1:0] pix_c_o
);

    logic chk_c;

    // Pattern select; checker square parity comes from the CHK bit of p and y.
    always_comb begin
        pix_c_o = '0;
        chk_c   = |(((p_i >> CHK) ^ (y_i >> CHK)) & PW'(1));
        case (mode_i)
            TPTN_HRAMP: pix_c_o = p_i + f_i;
            TPTN_CHECK: pix_c_o = {PW{chk_c}};
            TPTN_FIXED: pix_c_o = fix_i;
            TPTN_VRAMP: pix_c_o = y_i + f_i;
            default:    pix_c_o = '0;
        endcase
    end

endmodule

// File: rtl/cl_tptn_gen.sv
// Camera Link test-pattern source: frames of H_LEN lines x L_LEN tap-cycles,
// TAPS pixels per clock, programmable H/V blanking and four patterns.
// Optional feature macro CL_TPTN_FNUM_EN: tap 0 of the first pixel of line 0
// carries the low PW bits of the frame counter instead of the pattern.
module cl_tptn_gen
    import cl_tptn_gen_pkg::*;
#(
    parameter int unsigned PW    = 8,
    parameter int unsigned TAPS  = 3,
    parameter int unsigned L_LEN = 6,
    parameter int unsigned H_LEN = 4,
    parameter int unsigned HBLK  = 2,
    parameter int unsigned VBLK  = 3,
    parameter int unsigned FVS   = 1,
    parameter int unsigned CHK   = 2
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [PW-1:0]        fix_val,
    output logic [PW*TAPS+2:0]   dout,
    output logic                 busy,
    output logic                 frame_end
);

    localparam int unsigned DW = PW * TAPS;
    localparam int unsigned XW = cnt_w(L_LEN);
    localparam int unsigned YW = cnt_w(H_LEN);
    localparam int unsigned BW = cnt_w(max3(FVS, HBLK, VBLK));

    localparam logic [XW-1:0] X_LAST = XW'(L_LEN - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H_LEN - 1);
    localparam logic [BW-1:0] B_FVS  = BW'(FVS - 1);
    localparam logic [BW-1:0] B_HBLK = BW'(HBLK - 1);
    localparam logic [BW-1:0] B_VBLK = BW'(VBLK - 1);

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [BW-1:0]     b_q, b_d;
    logic [FW-1:0]     f_q, f_d;
    mode_e             mode_q, mode_d;
    logic [PW-1:0]     fix_q, fix_d;
    logic [DW+2:0]     dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              fe_q, fe_d;

    cl_ctl_t                    ctl_c;
    logic [TAPS-1:0][PW-1:0]    tap_c;
    logic [DW-1:0]              pix_c;

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign frame_end = fe_q;
    assign pix_c     = tap_c;

    // Per-tap pixel values for the current tap-cycle; tap 0 lands in the LSBs.
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic [PW-1:0] p_c;
        logic [PW-1:0] val_c;

        assign p_c = PW'(32'(x_q) * TAPS + 32'(t));

        cl_tptn_gen_pix #(
            .PW  (PW),
            .CHK (CHK)
        ) u_pix (
            .mode_i  (mode_q),
            .p_i     (p_c),
            .y_i     (PW'(y_q)),
            .f_i     (PW'(f_q)),
            .fix_i   (fix_q),
            .pix_c_o (val_c)
        );

`ifdef CL_TPTN_FNUM_EN
        if (t == 0) begin : g_fnum
            assign tap_c[t] = (x_q == '0 && y_q == '0) ? PW'(f_q) : val_c;
        end else begin : g_pat
            assign tap_c[t] = val_c;
        end
`else
        assign tap_c[t] = val_c;
`endif
    end

    // State, counters, latched frame settings and output registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            mode_q  <= TPTN_HRAMP;
            fix_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            b_q     <= b_d;
            f_q     <= f_d;
            mode_q  <= mode_d;
            fix_q   <= fix_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
        end
    end

    // Frame sequencing; outputs are decoded from the current state so they
    // appear one edge after the state is entered.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        b_d     = b_q;
        f_d     = f_q;
        mode_d  = mode_q;
        fix_d   = fix_q;
        fe_d    = 1'b0;
        busy_d  = (state_q != ST_IDLE);
        ctl_c   = '0;
        dout_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FSETUP;
                    b_d     = '0;
                end
            end
            ST_FSETUP: begin
                ctl_c.fval = 1'b1;
                if (b_q == B_FVS) begin
                    state_d = ST_LINE;
                    b_d     = '0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            ST_LINE: begin
                ctl_c = '{dval: 1'b1, fval: 1'b1, lval: 1'b1};
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    b_d     = '0;
                    state_d = (y_q == Y_LAST) ? ST_VBLANK : ST_HBLANK;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            ST_HBLANK: begin
                ctl_c.fval = 1'b1;
                if (b_q == B_HBLK) begin
                    state_d = ST_LINE;
                    b_d     = '0;
                    y_d     = y_q + YW'(1);
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            ST_VBLANK: begin
                if (b_q == B_VBLK) begin
                    fe_d    = 1'b1;
                    b_d     = '0;
                    y_d     = '0;
                    state_d = en ? ST_FSETUP : ST_IDLE;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fe_d) begin
            f_d = f_q + FW'(1);
        end

        // Pattern settings are frozen for the whole frame at FSETUP entry.
        if (state_d == ST_FSETUP && state_q != ST_FSETUP) begin
            mode_d = mode_e'(mode);
            fix_d  = fix_val;
        end

        dout_d = {ctl_c, ctl_c.lval ? pix_c : DW'(0)};
    end

endmodule

// File: tb/tb_cl_tptn_gen.sv
// Scoreboard bench for cl_tptn_gen: the stimulus process pushes whole-frame
// expected pixel words from a spec-level model; a negedge monitor pops and
// compares them and checks framing (line/frame lengths, FVS, frame_end, busy).
module tb_cl_tptn_gen;

    localparam int unsigned PW    = 8;
    localparam int unsigned TAPS  = 3;
    localparam int unsigned L_LEN = 6;
    localparam int unsigned H_LEN = 6;
    localparam int unsigned HBLK  = 2;
    localparam int unsigned VBLK  = 3;
    localparam int unsigned FVS   = 1;
    localparam int unsigned CHK   = 2;
    localparam int unsigned DW    = PW * TAPS;
    localparam int unsigned FRAME_HI = FVS + H_LEN * L_LEN + (H_LEN - 1) * HBLK;
    localparam int          NFR   = 9;
    localparam int          BUDGET = 500;

    localparam int SEL_FV = 0;
    localparam int SEL_LV = 1;
    localparam int SEL_FE = 2;

    logic              CLK;
    logic              RST_X;
    logic              en;
    logic [1:0]        mode;
    logic [PW-1:0]     fix_val;
    logic [DW+2:0]     dout;
    logic              busy;
    logic              frame_end;

    int n_vec = 0;
    int n_mis = 0;
    logic [DW-1:0] exp_q[$];
    bit mon_en = 0;

    cl_tptn_gen #(
        .PW(PW), .TAPS(TAPS), .L_LEN(L_LEN), .H_LEN(H_LEN),
        .HBLK(HBLK), .VBLK(VBLK), .FVS(FVS), .CHK(CHK)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .en        (en),
        .mode      (mode),
        .fix_val   (fix_val),
        .dout      (dout),
        .busy      (busy),
        .frame_end (frame_end)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pattern value straight from the mode definitions, modulo 2**PW.
    function automatic logic [PW-1:0] ref_pix(input int m, input int p, input int y,
                                              input int f, input int fx);
        int v;
        case (m)
            0:       v = p + f;
            1:       v = (((p / (1 << CHK)) + (y / (1 << CHK))) % 2 == 1) ? (1 << PW) - 1 : 0;
            2:       v = fx;
            default: v = y + f;
        endcase
        return PW'(v % (1 << PW));
    endfunction

    task automatic push_frame(input int m, input int fx, input int f);
        for (int y = 0; y < int'(H_LEN); y++) begin
            for (int x = 0; x < int'(L_LEN); x++) begin
                logic [DW-1:0] w;
                for (int t = 0; t < int'(TAPS); t++) begin
                    logic [PW-1:0] v;
                    v = ref_pix(m, x * int'(TAPS) + t, y, f, fx);
`ifdef CL_TPTN_FNUM_EN
                    if (x == 0 && y == 0 && t == 0) v = PW'(f % (1 << PW));
`endif
                    w[t*PW +: PW] = v;
                end
                exp_q.push_back(w);
            end
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_FV:  return dout[DW+1];
            SEL_LV:  return dout[DW];
            default: return frame_end;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input string nm);
        bit hit;
        hit = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge CLK);
            if (sig(sel) == val) begin
                hit = 1;
                break;
            end
        end
        n_vec++;
        if (!hit) begin
            n_mis++;
            $display("FAIL wait_%s: level %0b not seen within %0d cycles", nm, val, BUDGET);
        end
    endtask

    // Monitor: pops expected pixels and checks framing every cycle.
    int   cnt_l, cnt_fh, cnt_lo, lines;
    logic prev_lv, prev_fv, prev_fe;
    logic m_dv, m_fv, m_lv;
    logic [DW-1:0] m_px;

    always @(negedge CLK) begin
        if (!mon_en) begin
            cnt_l = 0; cnt_fh = 0; cnt_lo = 0; lines = 0;
            prev_lv = 0; prev_fv = 0; prev_fe = 0;
        end else begin
            m_dv = dout[DW+2];
            m_fv = dout[DW+1];
            m_lv = dout[DW];
            m_px = dout[DW-1:0];
            check("dval_eq_lval", 64'(m_dv), 64'(m_lv));
            if (m_lv) begin
                check("lval_in_fval", 64'(m_fv), 64'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL pixel: got 0x%0h with no pixel expected", m_px);
                end else begin
                    check("pixel", 64'(m_px), 64'(exp_q.pop_front()));
                end
            end else begin
                check("blank_pix_zero", 64'(m_px), 64'd0);
            end
            if (m_fv) check("busy_with_fval", 64'(busy), 64'd1);
            if (prev_fe) check("busy_after_frame_end", 64'(busy), 64'(m_fv));
            if (m_lv && !prev_lv) begin
                if (lines == 0) check("fvs_len", 64'(cnt_fh), 64'(FVS));
                lines++;
            end
            if (!m_lv && prev_lv) begin
                check("line_len", 64'(cnt_l), 64'(L_LEN));
                cnt_l = 0;
            end
            if (!m_fv && prev_fv) begin
                check("fval_high_len", 64'(cnt_fh), 64'(FRAME_HI));
                check("lines_per_frame", 64'(lines), 64'(H_LEN));
                cnt_fh = 0;
                lines = 0;
            end
            if (m_fv) begin
                cnt_fh++;
                cnt_lo = 0;
            end else begin
                cnt_lo++;
            end
            if (m_lv) cnt_l++;
            if (frame_end) check("frame_end_pos", 64'(cnt_lo), 64'(VBLK));
            prev_lv = m_lv;
            prev_fv = m_fv;
            prev_fe = frame_end;
        end
    end

    // Stimulus.
    initial begin
        int nm, nf, seen;
        RST_X = 1'b0; en = 1'b0; mode = 2'd0; fix_val = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_end", 64'(frame_end), 64'd0);
        @(negedge CLK) RST_X = 1'b1;
        @(posedge CLK); #1 mon_en = 1;

        // Back-to-back frames; each frame's settings change mid-way through the previous one.
        @(negedge CLK);
        mode = 2'd0; fix_val = PW'($urandom);
        push_frame(0, int'(fix_val), 0);
        en = 1'b1;
        for (int i = 0; i < NFR; i++) begin
            wait_sig(SEL_FV, 1'b1, "fval_rise");
            if (i < NFR - 1) begin
                if (i + 1 == 7)      begin nm = 2; nf = 'h5A; end
                else if (i + 1 == 1) begin nm = 1; nf = 0; end
                else if (i + 1 == 2) begin nm = 3; nf = 0; end
                else                 begin nm = int'($urandom_range(0, 3)); nf = int'($urandom_range(0, 255)); end
                mode = 2'(nm); fix_val = PW'(nf);
                push_frame(nm, nf, i + 1);
                wait_sig(SEL_FV, 1'b0, "fval_fall");
            end else begin
                // Drop en around line 2 and disturb mode; the frame must still complete.
                repeat (FVS + 2 * (L_LEN + HBLK)) @(negedge CLK);
                en = 1'b0;
                mode = ~mode; fix_val = ~fix_val;
                wait_sig(SEL_FE, 1'b1, "frame_end");
                @(negedge CLK);
                check("busy_fall", 64'(busy), 64'd0);
                check("idle_fval", 64'(dout[DW+1]), 64'd0);
                seen = 0;
                repeat (20) begin
                    @(negedge CLK);
                    if (dout[DW+1] || busy) seen++;
                end
                check("no_restart", 64'(seen), 64'd0);
            end
        end

        // Async reset in the middle of a line, then restart from frame 0.
        @(posedge CLK); #1 mon_en = 0;
        @(negedge CLK);
        mode = 2'd3; en = 1'b1;
        wait_sig(SEL_LV, 1'b1, "lval_before_reset");
        repeat (2) @(negedge CLK);
        #2 RST_X = 1'b0;
        #1;
        check("async_rst_dout", 64'(dout), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_frame_end", 64'(frame_end), 64'd0);
        en = 1'b0;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK); #1 mon_en = 1;
        @(negedge CLK);
        mode = 2'd0; fix_val = PW'($urandom);
        push_frame(0, int'(fix_val), 0);
        en = 1'b1;
        wait_sig(SEL_FV, 1'b1, "fval_after_reset");
        en = 1'b0;
        wait_sig(SEL_FE, 1'b1, "frame_end_after_reset");
        @(negedge CLK);
        check("busy_fall_after_reset", 64'(busy), 64'd0);
        repeat (3) @(negedge CLK);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
